alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_core.sv | 40 ++++
 rtl/alu_multicycle.sv | 167 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the multicycle ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU slice: AND/ADD/SUB/OR with carry.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] y_o,
    output logic             carry_o
);
    import alu_pkg::*;

    logic [WIDTH:0] sum;

    always_comb begin
        sum     = '0;
        y_o     = '0;
        carry_o = 1'b0;
        case (op_i)
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_ADD: begin
                sum     = {1'b0, a_i} + {1'b0, b_i};
                y_o     = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
            end
            OP_SUB: begin
                // Carry-out of a + ~b + 1 is the "no borrow" flag (a >= b unsigned).
                sum     = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
                y_o     = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
            end
            default: begin
                y_o     = '0;
                carry_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic ops via alu_core, bit-serial shifts and shift-add multiply.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [2:0]       AluOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z,
    output logic             ZeroFlag,
    output logic             CarryFlag
);
    import alu_pkg::*;

    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             zf_q, zf_d;
    logic             cf_q, cf_d;

    logic [WIDTH-1:0] core_y;
    logic             core_c;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_lo, step_hi;
    logic             step_out;
    logic             upd;

    assign shamt = Y[SHW-1:0];

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i     (X),
        .b_i     (Y),
        .op_i    (AluOp),
        .y_o     (core_y),
        .carry_o (core_c)
    );

    // One iteration step; for MUL {hi,lo} is the partial product shifted right each step.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        step_lo  = lo_q;
        step_hi  = hi_q;
        step_out = 1'b0;
        case (op_q)
            OP_SLL: begin
                step_lo  = lo_q << 1;
                step_out = lo_q[WIDTH-1];
            end
            OP_SRL: begin
                step_lo  = lo_q >> 1;
                step_out = lo_q[0];
            end
            OP_MUL: begin
                step_hi  = mul_sum[WIDTH:1];
                step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
                step_out = |mul_sum[WIDTH:1];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        z_d     = z_q;
        cf_d    = cf_q;
        upd     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = AluOp;
                    case (AluOp)
                        OP_SLL, OP_SRL: begin
                            // Zero shift completes like a single-cycle op so latency stays shamt+1.
                            if (shamt == '0) begin
                                state_d = S_DONE;
                                z_d     = X;
                                cf_d    = 1'b0;
                                upd     = 1'b1;
                            end else begin
                                state_d = S_ITER;
                                cnt_d   = {1'b0, shamt};
                                lo_d    = X;
                                hi_d    = '0;
                            end
                        end
                        OP_MUL: begin
                            state_d = S_ITER;
                            cnt_d   = CNT_MUL;
                            a_d     = X;
                            lo_d    = Y;
                            hi_d    = '0;
                        end
                        default: begin
                            state_d = S_DONE;
                            z_d     = core_y;
                            cf_d    = core_c;
                            upd     = 1'b1;
                        end
                    endcase
                end
            end
            S_ITER: begin
                lo_d  = step_lo;
                hi_d  = step_hi;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                    z_d     = step_lo;
                    cf_d    = step_out;
                    upd     = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        zf_d = upd ? (z_d == '0) : zf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            z_q     <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            z_q     <= z_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign Z         = z_q;
    assign ZeroFlag  = zf_q;
    assign CarryFlag = cf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] X, Y;
    logic [2:0]  AluOp;
    logic        busy, done;
    logic [31:0] Z;
    logic        ZeroFlag, CarryFlag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X         (X),
        .Y         (Y),
        .AluOp     (AluOp),
        .busy      (busy),
        .done      (done),
        .Z         (Z),
        .ZeroFlag  (ZeroFlag),
        .CarryFlag (CarryFlag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency counts the accept edge as edge 1.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ez, input logic ezf,
                          input logic ecf, input int elat);
        int lat;
        AluOp = op;
        X     = x;
        Y     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        X     = $urandom;
        Y     = $urandom;
        AluOp = 3'($urandom);
        lat   = 1;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".Z"}, Z, ez);
        chk({tag, ".zf"}, {31'd0, ZeroFlag}, {31'd0, ezf});
        chk({tag, ".cf"}, {31'd0, CarryFlag}, {31'd0, ecf});
        tick();
        chk({tag, ".done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, dlat, pulses;
        logic [7:0] pat;

        rst   = 1'b1;
        start = 1'b1;
        AluOp = OP_AND;
        X     = 32'hFFFF_FFFF;
        Y     = 32'hFFFF_FFFF;
        repeat (2) tick();
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.Z", Z, 32'd0);
        chk("rst.zf", {31'd0, ZeroFlag}, 32'd0);
        chk("rst.cf", {31'd0, CarryFlag}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();

        run_op("and",   OP_AND, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_0000, 1'b0, 1'b0, 1);
        run_op("sub_eq", OP_SUB, 32'hAAAA_FFFF, 32'hAAAA_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1);
        run_op("sub_lt", OP_SUB, 32'h4512_ACD2, 32'hAAAA_FFFF, 32'h9A67_ACD3, 1'b0, 1'b0, 1);
        run_op("add_ov", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1);
        run_op("sll31", OP_SLL, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
        run_op("srl1",  OP_SRL, 32'h0000_0003, 32'd1, 32'h0000_0001, 1'b0, 1'b1, 2);
        run_op("sll0",  OP_SLL, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 1);
        run_op("sll1c", OP_SLL, 32'hC000_0000, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 2);
        run_op("srl_hi", OP_SRL, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0, 1'b0, 2);
        run_op("mul_hi", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b1, 33);
        run_op("mul_ff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 33);
        run_op("rsvd",  OP_RSVD, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1);
        run_op("or",    OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1);

        // MUL 7*6 with a stray AND start during ITER
        AluOp = OP_MUL;
        X     = 32'd7;
        Y     = 32'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        repeat (4) begin
            tick();
            lat++;
        end
        chk("mul7.busy_iter", {31'd0, busy}, 32'd1);
        chk("mul7.Z_held", Z, 32'h0000_00FF);
        AluOp = OP_AND;
        X     = 32'hFFFF_FFFF;
        Y     = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        pulses = 0;
        dlat   = 0;
        while (lat < 40) begin
            if (done) begin
                pulses++;
                if (pulses == 1) dlat = lat;
            end
            tick();
            lat++;
        end
        chk("mul7.pulses", pulses, 1);
        chk("mul7.lat", dlat, 33);
        chk("mul7.Z", Z, 32'h0000_002A);
        chk("mul7.cf", {31'd0, CarryFlag}, 32'd0);
        chk("mul7.zf", {31'd0, ZeroFlag}, 32'd0);

        // back-to-back with start held high
        AluOp = OP_AND;
        X     = 32'd3;
        Y     = 32'd1;
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            pat[i] = done;
        end
        start = 1'b0;
        chk("b2b.pattern", {24'd0, pat}, 32'h0000_0055);
        chk("b2b.Z", Z, 32'd1);
        tick();
        chk("b2b.idle", {31'd0, busy}, 32'd0);

        // reset abort in the middle of MUL
        run_op("add_pre", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b1, 1);
        AluOp = OP_MUL;
        X     = 32'h0001_0000;
        Y     = 32'h0001_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("abort.busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.Z", Z, 32'd0);
        chk("abort.zf", {31'd0, ZeroFlag}, 32'd0);
        chk("abort.cf", {31'd0, CarryFlag}, 32'd0);
        pulses = 0;
        repeat (40) begin
            tick();
            if (done) pulses++;
        end
        chk("abort.no_done", pulses, 0);
        run_op("and_post", OP_AND, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_0000, 1'b0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
